// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage RISC-V pipeline: operand forwarding,
// load-use stalls, branch flushes and data-memory wait sequencing with timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      ResultSrcE_i,
  input  logic                      PCSrcE_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  input  logic                      ResultSrcM_i,
  input  logic                      MemWriteM_i,
  input  logic                      mem_ready_i,
  output logic                      MemReqM_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      StallE_o,
  output logic                      StallM_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic                      FlushW_o,
  output logic                      mem_timeout_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout_q;
  logic             acc;
  logic             abandon;
  logic             lw_stall;
  logic             mem_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic                      wr_m,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic                      wr_w,
    input logic [REG_ADDR_WIDTH-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign acc = ResultSrcM_i | MemWriteM_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      timeout_q <= timeout_q | abandon;
    end
  end

  // cnt counts stall cycles already spent; the first stall cycle happens in IDLE,
  // so reaching MEM_TIMEOUT in WAIT means the budget is used up.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    abandon    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc && !mem_ready_i) begin
          state_next = ST_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          abandon    = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    lw_stall  = ResultSrcE_i && (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    mem_stall = acc && !mem_ready_i && !abandon;

    ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
    ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
    MemReqM_o   = acc && rst_n;

    StallF_o = lw_stall;
    StallD_o = lw_stall;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = PCSrcE_i;
    FlushE_o = lw_stall || PCSrcE_i;
    FlushW_o = 1'b0;
    // A memory stall freezes everything up to EX/MEM; the branch/load in E is kept
    // intact so it is re-evaluated once the access completes.
    if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushW_o = 1'b1;
    end
  end

  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          ResultSrcE, PCSrcE, RegWriteM, RegWriteW, ResultSrcM, MemWriteM, mem_ready;
  logic          MemReqM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Model: stall cycles already spent on the current access, and the sticky flag.
  int   m_wait = 0;
  logic m_to   = 1'b0;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE),
    .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .ResultSrcM_i(ResultSrcM), .MemWriteM_i(MemWriteM), .mem_ready_i(mem_ready),
    .MemReqM_o(MemReqM), .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
    .mem_timeout_o(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_mem_stall();
    return (ResultSrcM || MemWriteM) && !mem_ready && (m_wait < TMO);
  endfunction

  // {MemReq, FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, timeout}
  function automatic logic [12:0] exp_vec();
    logic lw, ms;
    logic [7:0] ctl;
    lw = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    ms = m_mem_stall();
    if (ms) ctl = 8'b1111_0010;
    else    ctl = {lw, lw, 1'b0, 1'b0, PCSrcE, lw || PCSrcE, 1'b0, 1'b0};
    ctl[0] = m_to;
    return {(ResultSrcM || MemWriteM) && rst_n, m_fwd(Rs1E), m_fwd(Rs2E), ctl};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {MemReqM, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
            FlushD, FlushE, FlushW, mem_timeout};
  endfunction

  // Advance one clock and update the model from the inputs applied in that cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0;
      m_to   = 1'b0;
    end else if ((ResultSrcM || MemWriteM) && !mem_ready) begin
      if (m_wait >= TMO) begin
        m_to   = 1'b1;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, ResultSrcM, MemWriteM, mem_ready} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n  = 1'b0;
    m_wait = 0;
    m_to   = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (obs_vec() !== 13'b0) begin
      $display("FAIL reset_state obs=%b exp=%b", obs_vec(), 13'b0);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a [3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 9; end
        1: RegWriteM = 0;
        default: begin RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1; end
      endcase
      #1;
      vectors++;
      if (ForwardAE !== exp_a[i]) begin
        $display("FAIL fwd_a_%0d obs=%b exp=%b", i, ForwardAE, exp_a[i]);
        miscompares++;
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL fwd_vec_%0d obs=%b exp=%b", i, obs_vec(), exp_vec());
        miscompares++;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    ResultSrcE = 1; RdE = 7; Rs2D = 7; Rs1D = 3;
    #1;
    vectors++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      $display("FAIL load_use obs=%b exp=%b", {StallF, StallD, FlushE, FlushD}, 4'b1110);
      miscompares++;
    end
    tick();
    RdE = 0; Rs2D = 0;
    #1;
    vectors++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
      $display("FAIL load_use_rd0 obs=%b exp=%b", {StallF, StallD, FlushE, FlushD}, 4'b0000);
      miscompares++;
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    PCSrcE = 1;
    #1;
    vectors++;
    if ({FlushD, FlushE, StallF, StallD, StallE, StallM} !== 6'b110000) begin
      $display("FAIL branch obs=%b exp=%b", {FlushD, FlushE, StallF, StallD, StallE, StallM}, 6'b110000);
      miscompares++;
    end
    tick();
    ResultSrcE = 1; RdE = 4; Rs1D = 4;
    #1;
    vectors++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin
      $display("FAIL branch_lw obs=%b exp=%b", {FlushD, FlushE, StallF, StallD}, 4'b1111);
      miscompares++;
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    ResultSrcM = 1; RdM = 2; PCSrcE = 1;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c == 4);
      #1;
      if (StallM) stalls++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL mem_wait_c%0d obs=%b exp=%b", c, obs_vec(), exp_vec());
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (stalls != 3) begin
      $display("FAIL mem_wait_stalls obs=%0d exp=3", stalls);
      miscompares++;
    end
    clear_inputs();
    #1;
    vectors++;
    if (mem_timeout !== 1'b0) begin
      $display("FAIL mem_wait_no_timeout obs=%b exp=0", mem_timeout);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int stalls = 0;
    ResultSrcM = 1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    m_wait = 0;
    m_to   = 1'b0;
    #1;
    vectors++;
    if ({MemReqM, mem_timeout} !== 2'b00) begin
      $display("FAIL reset_mid_wait obs=%b exp=00", {MemReqM, mem_timeout});
      miscompares++;
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL reset_mid_wait_vec obs=%b exp=%b", obs_vec(), exp_vec());
      miscompares++;
    end
    #1 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      if (StallM) stalls++;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL restart_c%0d obs=%b exp=%b", c, obs_vec(), exp_vec());
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (stalls != TMO - 1) begin
      $display("FAIL restart_stalls obs=%0d exp=%0d", stalls, TMO - 1);
      miscompares++;
    end
  endtask

  task automatic test_random();
    bit active = 0;
    bit kind   = 0;
    int remaining = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      ResultSrcE = 1'($urandom_range(0, 1)); PCSrcE    = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      if (!active && $urandom_range(0, 1) == 1) begin
        active    = 1;
        kind      = 1'($urandom_range(0, 1));
        remaining = $urandom_range(0, TMO + 2);
      end
      ResultSrcM = active && kind;
      MemWriteM  = active && !kind;
      mem_ready  = active ? (remaining == 0) : 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random_%0d obs=%b exp=%b", n, obs_vec(), exp_vec());
        miscompares++;
      end
      if (active) begin
        if (mem_ready || m_wait >= TMO) active = 0;
        else remaining--;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    MemWriteM = 1;
    for (int c = 1; c <= TMO + 1; c++) begin
      #1;
      vectors++;
      if ({StallM, FlushW, mem_timeout} !== {(c <= TMO), (c <= TMO), 1'b0}) begin
        $display("FAIL timeout_c%0d obs=%b exp=%b", c, {StallM, FlushW, mem_timeout},
                 {(c <= TMO), (c <= TMO), 1'b0});
        miscompares++;
      end
      tick();
    end
    clear_inputs();
    #1;
    vectors++;
    if (mem_timeout !== 1'b1) begin
      $display("FAIL timeout_set obs=%b exp=1", mem_timeout);
      miscompares++;
    end
    for (int c = 0; c < 10; c++) tick();
    vectors++;
    if (mem_timeout !== 1'b1) begin
      $display("FAIL timeout_sticky obs=%b exp=1", mem_timeout);
      miscompares++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
